// File: rtl/memory_arbiter_pkg.sv
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared types and helpers for the memory arbiter slice.
//               Option macro: MEMORY_ARBITER_PRIORITY_EN (fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_arbiter_pkg;

  // One response may be outstanding at a time, so two states are enough.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Requester index width; a single-bit id is kept even for degenerate sizes.
  function automatic int id_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_rr.sv
// ============================================================================
// Module      : arbiter_rr
// Description : Combinational PORTS-wide request picker. Round-robin by
//               default (search starts one past the previous winner);
//               lowest-index fixed priority when MEMORY_ARBITER_PRIORITY_EN
//               is defined, in which case the last pointer is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_rr
  import memory_arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IW    = id_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [PORTS-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic          w_found;
  logic [IW-1:0] w_pos;

`ifdef MEMORY_ARBITER_PRIORITY_EN
  // The pointer only exists for round-robin; fold it away here.
  logic w_unused_last;
  assign w_unused_last = ^last;

  // Lowest asserted index wins unconditionally.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_pos = IW'(i);
      if (!w_found && req[w_pos]) begin
        w_found    = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
      end
    end
  end
`else
  // Walk the ports starting just after the previous winner, wrapping round;
  // the previous winner itself is visited last.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= PORTS; k++) begin
      w_pos = IW'((int'(last) + k) % PORTS);
      if (!w_found && req[w_pos]) begin
        w_found    = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one synchronous-read memory between PORTS read
//               requesters. One read is outstanding at most; the response is
//               the memory output passed straight through, tagged with the
//               requester id. Option macro MEMORY_ARBITER_PRIORITY_EN swaps
//               round-robin for fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int  PORTS = 4,
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = id_width(PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    req_stb,
  input  logic [PORTS*AW-1:0] req_adr,
  output logic [PORTS-1:0]    req_ack,
  output logic                rsp_stb,
  output logic [WIDTH-1:0]    rsp_dat,
  output logic [IW-1:0]       rsp_id,
  input  logic                rsp_ack,
  output logic                mem_en,
  output logic [AW-1:0]       mem_adr,
  input  logic [WIDTH-1:0]    mem_dat
);

  state_t           state_q, state_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [PORTS-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_issue;

`ifdef MEMORY_ARBITER_PRIORITY_EN
  arbiter_rr #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_arbiter (
    .req  (req_stb),
    .last ({IW{1'b0}}),
    .gnt  (w_gnt),
    .idx  (w_idx)
  );
`else
  logic [IW-1:0] last_q, last_d;

  arbiter_rr #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_arbiter (
    .req  (req_stb),
    .last (last_q),
    .gnt  (w_gnt),
    .idx  (w_idx)
  );

  // The pointer only moves when a read is actually issued.
  always_comb begin
    last_d = w_issue ? w_idx : last_q;
  end

  // Reset to PORTS-1 so the first search starts at port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IW'(PORTS - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Issue when nothing is pending or the pending response is being consumed
  // this cycle; reset suppresses grants so no read starts while it is held.
  always_comb begin
    w_issue  = ((state_q == IDLE) || rsp_ack) && (|req_stb) && !rst;
    req_ack  = w_issue ? w_gnt : '0;
    mem_en   = w_issue;
    mem_adr  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (w_issue && w_gnt[i]) begin
        mem_adr = mem_adr | req_adr[i*AW +: AW];
      end
    end
    rsp_id_d = w_issue ? w_idx : rsp_id_q;
    if (w_issue) begin
      state_d = BUSY;
    end else if ((state_q == BUSY) && !rsp_ack) begin
      state_d = BUSY;
    end else begin
      state_d = IDLE;
    end
  end

  // FSM state and the id of the outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  // The memory holds its output while mem_en is low, so data passes through.
  assign rsp_stb = (state_q == BUSY);
  assign rsp_dat = mem_dat;
  assign rsp_id  = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter: directed vector table,
//               randomized traffic against a transaction-level model, and a
//               fixed-priority sequence when MEMORY_ARBITER_PRIORITY_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

  localparam int PORTS = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int IW    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [PORTS-1:0]    req_stb;
  logic [PORTS*AW-1:0] req_adr;
  logic [PORTS-1:0]    req_ack;
  logic                rsp_stb;
  logic [WIDTH-1:0]    rsp_dat;
  logic [IW-1:0]       rsp_id;
  logic                rsp_ack;
  logic                mem_en;
  logic [AW-1:0]       mem_adr;
  logic [WIDTH-1:0]    mem_dat;

  logic [WIDTH-1:0]    mem [DEPTH];

  int checks = 0;
  int errors = 0;

  memory_arbiter #(
    .PORTS (PORTS),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_stb (req_stb),
    .req_adr (req_adr),
    .req_ack (req_ack),
    .rsp_stb (rsp_stb),
    .rsp_dat (rsp_dat),
    .rsp_id  (rsp_id),
    .rsp_ack (rsp_ack),
    .mem_en  (mem_en),
    .mem_adr (mem_adr),
    .mem_dat (mem_dat)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: registered, en-gated, holds when en is low.
  always @(posedge clk) begin
    if (mem_en) mem_dat <= mem[mem_adr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic                rst;
    logic [3:0]          stb;
    logic [PORTS*AW-1:0] adr;
    logic                ack;
    logic [3:0]          e_ack;
    logic                e_en;
    logic [AW-1:0]       e_madr;
    logic                e_stb;
    logic [IW-1:0]       e_id;
    logic [WIDTH-1:0]    e_dat;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [3:0] s, input logic [PORTS*AW-1:0] a,
                             input logic k, input logic [3:0] ea, input logic ee,
                             input logic [AW-1:0] em, input logic es, input logic [IW-1:0] ei,
                             input logic [WIDTH-1:0] ed);
    vec_t t;
    t = '{rst: r, stb: s, adr: a, ack: k, e_ack: ea, e_en: ee, e_madr: em,
          e_stb: es, e_id: ei, e_dat: ed};
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    req_stb = '0;
    rsp_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Transaction-level model state for the random phase.
  int          last_m;
  bit          out_v;
  int          out_id;
  logic [7:0]  out_dat;
  int          wait_cnt [PORTS];
  int          drop;

  initial begin
    logic [PORTS*AW-1:0] a_rr, a_b0, a_b1;
    vec_t                tv [$];
    logic [3:0]          exp_ack;
    logic                exp_en;
    logic [AW-1:0]       exp_adr;
    int                  win;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 37 + 5);
    mem[12'h010] = 8'hA5;
    mem[12'h020] = 8'h11;
    mem[12'h030] = 8'h22;
    mem[12'h040] = 8'h33;
    mem[12'h000] = 8'h3C;
    mem[12'hFFF] = 8'hC3;

    rst     = 1'b1;
    req_stb = '0;
    req_adr = '0;
    rsp_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset rsp_stb", rsp_stb, 0);
    check("reset rsp_id",  rsp_id,  0);
    check("reset req_ack", req_ack, 0);
    check("reset mem_en",  mem_en,  0);
    check("reset mem_adr", mem_adr, 0);
    @(negedge clk);
    rst = 1'b0;

    // Port addresses {p3, p2, p1, p0}.
    a_rr = {12'h040, 12'h010, 12'h030, 12'h020};
    a_b0 = {12'h000, 12'h000, 12'h000, 12'h000};
    a_b1 = {12'h000, 12'h000, 12'hFFF, 12'h000};

`ifndef MEMORY_ARBITER_PRIORITY_EN
    tv.push_back(v(0, 4'b0100, a_rr, 1, 4'b0100, 1, 12'h010, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b0000, a_rr, 1, 4'b0000, 0, 12'h000, 1, 2, 8'hA5));
    tv.push_back(v(1, 4'b1111, a_rr, 1, 4'b0000, 0, 12'h000, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b0001, 1, 12'h020, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b0010, 1, 12'h030, 1, 0, 8'h11));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b0100, 1, 12'h010, 1, 1, 8'h22));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b1000, 1, 12'h040, 1, 2, 8'hA5));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b0001, 1, 12'h020, 1, 3, 8'h33));
    for (int i = 0; i < 5; i++)
      tv.push_back(v(0, 4'b1111, a_rr, 0, 4'b0000, 0, 12'h000, 1, 0, 8'h11));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b0010, 1, 12'h030, 1, 0, 8'h11));
    tv.push_back(v(0, 4'b0000, a_rr, 1, 4'b0000, 0, 12'h000, 1, 1, 8'h22));
    tv.push_back(v(0, 4'b0010, a_b0, 1, 4'b0010, 1, 12'h000, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b0010, a_b1, 1, 4'b0010, 1, 12'hFFF, 1, 1, 8'h3C));
    tv.push_back(v(0, 4'b0000, a_rr, 1, 4'b0000, 0, 12'h000, 1, 1, 8'hC3));
    tv.push_back(v(0, 4'b0001, a_rr, 1, 4'b0001, 1, 12'h020, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b0000, a_rr, 0, 4'b0000, 0, 12'h000, 1, 0, 8'h11));
    tv.push_back(v(1, 4'b1111, a_rr, 1, 4'b0000, 0, 12'h000, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b1111, a_rr, 1, 4'b0001, 1, 12'h020, 0, 0, 8'h00));
    tv.push_back(v(0, 4'b0000, a_rr, 1, 4'b0000, 0, 12'h000, 1, 0, 8'h11));

    for (int r = 0; r < tv.size(); r++) begin
      @(negedge clk);
      rst     = tv[r].rst;
      req_stb = tv[r].stb;
      req_adr = tv[r].adr;
      rsp_ack = tv[r].ack;
      #1;
      check($sformatf("vec%0d req_ack", r), req_ack, tv[r].e_ack);
      check($sformatf("vec%0d mem_en",  r), mem_en,  tv[r].e_en);
      check($sformatf("vec%0d mem_adr", r), mem_adr, tv[r].e_madr);
      check($sformatf("vec%0d rsp_stb", r), rsp_stb, tv[r].e_stb);
      if (tv[r].e_stb) begin
        check($sformatf("vec%0d rsp_id",  r), rsp_id,  tv[r].e_id);
        check($sformatf("vec%0d rsp_dat", r), rsp_dat, tv[r].e_dat);
      end
    end
`else
    // Ports 0 and 3 both request continuously; port 0 must win every grant.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_stb = 4'b1001;
      req_adr = a_rr;
      rsp_ack = 1'b1;
      #1;
      check($sformatf("prio%0d req_ack", c), req_ack, 4'b0001);
    end
`endif

    // Randomized traffic against the transaction-level model.
    do_reset();
    req_stb = '0;
    last_m  = PORTS - 1;
    out_v   = 1'b0;
    drop    = -1;
    for (int i = 0; i < PORTS; i++) wait_cnt[i] = 0;

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (drop >= 0) req_stb[drop] = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        if (!req_stb[i] && $urandom_range(0, 1) == 1) begin
          req_stb[i] = 1'b1;
          req_adr[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        end
      end
      rsp_ack = ($urandom_range(0, 9) < 7);
      #1;

      exp_ack = '0;
      exp_en  = 1'b0;
      exp_adr = '0;
      win     = -1;
      if ((!out_v || rsp_ack) && req_stb != 0) begin
`ifdef MEMORY_ARBITER_PRIORITY_EN
        for (int i = PORTS - 1; i >= 0; i--) if (req_stb[i]) win = i;
`else
        for (int k = PORTS; k >= 1; k--) if (req_stb[(last_m + k) % PORTS]) win = (last_m + k) % PORTS;
`endif
        exp_ack[win] = 1'b1;
        exp_en       = 1'b1;
        exp_adr      = req_adr[win*AW +: AW];
      end

      check("rnd rsp_stb", rsp_stb, out_v);
      if (out_v) begin
        check("rnd rsp_id",  rsp_id,  out_id);
        check("rnd rsp_dat", rsp_dat, out_dat);
      end
      check("rnd req_ack", req_ack, exp_ack);
      check("rnd mem_en",  mem_en,  exp_en);
      check("rnd mem_adr", mem_adr, exp_adr);

      if (out_v && rsp_ack) out_v = 1'b0;
      drop = win;
      if (win >= 0) begin
`ifndef MEMORY_ARBITER_PRIORITY_EN
        check("rnd starvation bound", (wait_cnt[win] < PORTS), 1);
`endif
        for (int i = 0; i < PORTS; i++) if (i != win && req_stb[i]) wait_cnt[i]++;
        wait_cnt[win] = 0;
        out_v   = 1'b1;
        out_id  = win;
        out_dat = mem[req_adr[win*AW +: AW]];
        last_m  = win;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one synchronous-read memory (1-cycle registered read, `en`-gated, data held while `en` low) between `PORTS` read requesters. Arbitrates each cycle, drives the memory's `en`/`adr` and returns the read data on a single shared response channel tagged with the requester index. Sits between the compute units that fetch weights or data and the memory instance they share.

## Interface
- `PORTS`, 4: number of requesters (≥2).
- `WIDTH`, 8: memory data width.
- `DEPTH`, 4096: memory depth. Address width `AW = $clog2(DEPTH)`; id width `IW = $clog2(PORTS)`.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_stb` in PORTS: per-port read request valid.
- `req_adr` in PORTS*AW: per-port address; port i occupies bits [i*AW +: AW].
- `req_ack` out PORTS: one-hot request accept; a request transfers when `req_stb[i] & req_ack[i]`.
- `rsp_stb` out 1: response valid.
- `rsp_dat` out WIDTH: read data, meaningful only while `rsp_stb`.
- `rsp_id` out IW: index of the port the response belongs to.
- `rsp_ack` in 1: response consumed.
- `mem_en` out 1: memory enable.
- `mem_adr` out AW: memory address.
- `mem_dat` in WIDTH: memory registered read data.

## Operation
- FSM has two states.
- **IDLE**: no response pending. If any `req_stb` is high, the arbiter picks winner g. It then asserts `req_ack[g]`, `mem_en=1` and `mem_adr=req_adr[g]` in the same cycle, registers `rsp_id<=g`, and moves to BUSY. With no request it stays in IDLE and holds `mem_en=0`.
- **BUSY**: `rsp_stb=1`, `rsp_dat=mem_dat` (direct passthrough). The memory holds `mem_dat` because `mem_en` is low.
  - `rsp_ack=0`: hold. No arbitration, `req_ack=0`, `mem_en=0`.
  - `rsp_ack=1` with a request pending: arbitrate, issue the next read in the same cycle, and stay in BUSY with the new `rsp_id`.
  - `rsp_ack=1` with no request: go to IDLE.
- Round-robin arbitration:
  - A `last` pointer holds the previous winner.
  - The search starts at `last+1` modulo PORTS and takes the first asserted `req_stb`.
  - `last` updates only on an issued read.
- `req_ack` is at most one-hot. It is never asserted for a port whose `req_stb` is low.
- Requesters must hold `req_stb` and `req_adr` stable until acked.
- Responses return in issue order. Only one response is ever outstanding.

## Timing
- Reset values:
  - state IDLE
  - `last = PORTS-1`, so port 0 wins first
  - `rsp_stb=0`, `rsp_id=0`
  - `req_ack=0`, `mem_en=0`, `mem_adr=0`
- `req_ack`, `mem_en` and `mem_adr` are combinational from state, `req_stb` and `rsp_ack`. `rsp_stb` and `rsp_id` come from registers.
- Latency: `rsp_stb` rises on the cycle after `req_ack`.
- Throughput: with `rsp_ack` tied high and continuous requests, one read completes per cycle.
- A stalled response (`rsp_ack=0`) blocks all new grants.
- Reset asserted mid-operation discards any in-flight read; no response is produced for it. After reset release, the first grant goes to the lowest-indexed requester.
- Starvation bound: in round-robin mode a requesting port is granted within PORTS issued reads.

## Configuration
- `MEMORY_ARBITER_PRIORITY_EN` undefined: round-robin arbitration as above.
- `MEMORY_ARBITER_PRIORITY_EN` defined: fixed priority, lowest asserted index always wins. The `last` pointer is removed, and starvation of high-index ports is permitted.

## Structure
- Package `memory_arbiter_pkg` holds:
  - the state enum `state_t {IDLE, BUSY}`
  - a function computing `IW` from PORTS
- Sub-module `arbiter_rr`: combinational PORTS-wide round-robin picker.
  - Inputs: request vector, `last` pointer.
  - Outputs: one-hot grant and encoded index.
  - It contains the fixed-priority variant under the same macro.
- The top level holds the FSM, the `last` register, `rsp_id` and the memory-side muxing.

## Test plan
- Reset then single request: port 2 requests `adr=0x010` with `mem[0x010]=0xA5` → `req_ack=0b0100` in the same cycle; next cycle `rsp_stb=1`, `rsp_dat=0xA5`, `rsp_id=2`.
- Round-robin fairness: all 4 ports request continuously with `rsp_ack=1` → grants in order 0,1,2,3,0, one per cycle, with each `rsp_id` matching its data.
- Backpressure: `rsp_ack` held low for 5 cycles with `rsp_stb` asserted → `rsp_dat`/`rsp_id` stable, `req_ack=0`, `mem_en=0`. Raising `rsp_ack` issues the next grant in the same cycle.
- Back-to-back to the same port: port 1 requests `adr 0x000` then `0xFFF` (wrap edge, DEPTH-1) → two responses on consecutive cycles with correct data.
- Reset during BUSY: assert `rst` while `rsp_stb=1` → `rsp_stb=0` immediately; after release no stale response appears, and port 0 wins a 4-way contention.
- With `MEMORY_ARBITER_PRIORITY_EN` defined: ports 0 and 3 request continuously → port 3 is never granted while port 0 requests.
